// File: rtl/mmss_display_driver.sv
// MM.SS multiplexed seven-segment driver: per-frame snapshot, sequential double-dabble to BCD,
// atomic commit, then a registered digit scan with leading blanking on each slot.
module mmss_display_driver #(
   parameter int REFRESH_DIV  = 16384,
   parameter int BLANK_CYCLES = 64
) (
   input  logic       clk_100M,
   input  logic       reset,
   input  logic [5:0] sec_binary,
   input  logic [5:0] min_binary,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       conv_busy
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] DIV_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);

   typedef enum logic [1:0] {IDLE, SNAP, CONV, COMMIT} state_t;

   state_t        state;
   logic [CW-1:0] div_cnt;
   logic [1:0]    digit;
   logic          frame_start;
   logic [2:0]    step;
   logic [5:0]    sec_snap, min_snap;
   logic [7:0]    sec_scr, min_scr;
   logic          sec_inv_s, min_inv_s;
   logic [7:0]    sec_bcd, min_bcd;
   logic          sec_inv, min_inv;
   logic [3:0]    sel_nib;
   logic          sel_inv;
   logic          blank;

   // One double-dabble step: adjust nibbles >= 5, then shift the next binary bit in.
   function automatic logic [7:0] dabble(input logic [7:0] s, input logic b);
      logic [7:0] t;
      t = s;
      if (t[3:0] >= 4'd5) t[3:0] = t[3:0] + 4'd3;
      if (t[7:4] >= 4'd5) t[7:4] = t[7:4] + 4'd3;
      return {t[6:0], b};
   endfunction

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'h7F;
      endcase
   endfunction

   // Slot timer; frame_start resets high so the first conversion starts right after reset.
   always_ff @(posedge clk_100M or posedge reset) begin
      if (reset) begin
         div_cnt     <= '0;
         digit       <= 2'd0;
         frame_start <= 1'b1;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt     <= '0;
         digit       <= digit + 2'd1;
         frame_start <= (digit == 2'd3);
      end else begin
         div_cnt     <= div_cnt + 1'b1;
         frame_start <= 1'b0;
      end
   end

   always_ff @(posedge clk_100M or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         step      <= 3'd0;
         conv_busy <= 1'b0;
         sec_snap  <= '0;
         min_snap  <= '0;
         sec_scr   <= '0;
         min_scr   <= '0;
         sec_inv_s <= 1'b0;
         min_inv_s <= 1'b0;
         sec_bcd   <= '0;
         min_bcd   <= '0;
         sec_inv   <= 1'b0;
         min_inv   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (frame_start) state <= SNAP;
            SNAP: begin
               sec_snap  <= sec_binary;
               min_snap  <= min_binary;
               sec_inv_s <= (sec_binary >= 6'd60);
               min_inv_s <= (min_binary >= 6'd60);
               sec_scr   <= '0;
               min_scr   <= '0;
               step      <= 3'd0;
               conv_busy <= 1'b1;
               state     <= CONV;
            end
            CONV: begin
               sec_scr  <= dabble(sec_scr, sec_snap[5]);
               min_scr  <= dabble(min_scr, min_snap[5]);
               sec_snap <= {sec_snap[4:0], 1'b0};
               min_snap <= {min_snap[4:0], 1'b0};
               step     <= step + 3'd1;
               if (step == 3'd5) begin
                  conv_busy <= 1'b0;
                  state     <= COMMIT;
               end
            end
            COMMIT: begin
               // Both values land in the same cycle so a scan never mixes two snapshots.
               sec_bcd <= sec_scr;
               min_bcd <= min_scr;
               sec_inv <= sec_inv_s;
               min_inv <= min_inv_s;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      sel_nib = 4'd0;
      sel_inv = 1'b0;
      case (digit)
         2'd0: begin sel_nib = sec_bcd[3:0]; sel_inv = sec_inv; end
         2'd1: begin sel_nib = sec_bcd[7:4]; sel_inv = sec_inv; end
         2'd2: begin sel_nib = min_bcd[3:0]; sel_inv = min_inv; end
         default: begin sel_nib = min_bcd[7:4]; sel_inv = min_inv; end
      endcase
   end

   assign blank = (div_cnt < BLANK_LIM);

   always_ff @(posedge clk_100M or posedge reset) begin
      if (reset) begin
         an  <= 4'b1111;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else if (blank) begin
         an  <= 4'b1111;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= ~(4'b0001 << digit);
         seg <= sel_inv ? 7'b0111111 : decode(sel_nib);
         dp  <= !((digit == 2'd2) && !sec_bcd[0]);
      end
   end

endmodule

// File: tb/tb_mmss_display_driver.sv
// Directed bench for mmss_display_driver with a 16-cycle slot and 2-cycle blanking.
module tb_mmss_display_driver;

   logic       clk_100M = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] sec_binary = 6'd0;
   logic [5:0] min_binary = 6'd0;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       conv_busy;

   int errors = 0;
   int checks = 0;
   int edge_cnt = 0;

   mmss_display_driver #(.REFRESH_DIV(16), .BLANK_CYCLES(2)) dut (
      .clk_100M   (clk_100M),
      .reset      (reset),
      .sec_binary (sec_binary),
      .min_binary (min_binary),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .conv_busy  (conv_busy)
   );

   always #5 clk_100M = ~clk_100M;

   // Rising edges since reset release; edge n shows div_cnt (n-1)%16 on the outputs.
   always @(posedge clk_100M) begin
      if (reset) edge_cnt <= 0;
      else       edge_cnt <= edge_cnt + 1;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic goto_edge(input int n);
      int guard;
      guard = 0;
      while (edge_cnt < n && guard < 5000) begin
         @(negedge clk_100M);
         guard++;
      end
      checks++;
      assert (edge_cnt == n) else begin
         errors++;
         $error("FAIL edge_sync: observed %0d expected %0d", edge_cnt, n);
      end
   endtask

   task automatic check_digit(input int f, input int d, input logic [6:0] exp_seg, input logic exp_dp);
      logic [3:0] a_exp;
      a_exp = ~(4'b0001 << d);
      goto_edge(64 * f + 16 * d + 13);
      check($sformatf("f%0d_d%0d_an", f, d), {4'h0, an}, {4'h0, a_exp});
      check($sformatf("f%0d_d%0d_seg", f, d), {1'b0, seg}, {1'b0, exp_seg});
      check($sformatf("f%0d_d%0d_dp", f, d), {7'h0, dp}, {7'h0, exp_dp});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_an"}, {4'h0, an}, 8'h0F);
      check({tag, "_seg"}, {1'b0, seg}, 8'h7F);
      check({tag, "_dp"}, {7'h0, dp}, 8'h01);
      check({tag, "_busy"}, {7'h0, conv_busy}, 8'h00);
   endtask

   initial begin
      logic [3:0] a_exp;
      int p;
      int d;

      // Reset state, then release on a falling edge.
      repeat (3) @(negedge clk_100M);
      check_reset_outputs("rst");
      reset = 1'b0;

      for (int n = 1; n <= 8; n++) begin
         goto_edge(n);
         check($sformatf("busy_e%0d", n), {7'h0, conv_busy}, {7'h0, (n >= 2 && n <= 7)});
         if (n == 1) check("first_blank_an", {4'h0, an}, 8'h0F);
      end

      // Frame 0: 00.00, separator lit because seconds are even.
      check_digit(0, 0, 7'h40, 1'b1);
      check_digit(0, 1, 7'h40, 1'b1);
      check_digit(0, 2, 7'h40, 1'b0);
      check_digit(0, 3, 7'h40, 1'b1);

      // Frame 1: 59.59, separator dark for an odd second.
      min_binary = 6'd59;
      sec_binary = 6'd59;
      check_digit(1, 0, 7'h10, 1'b1);
      check_digit(1, 1, 7'h12, 1'b1);
      check_digit(1, 2, 7'h10, 1'b1);
      check_digit(1, 3, 7'h12, 1'b1);

      // Frame 2: seconds out of range show dashes, minutes still 12.
      min_binary = 6'd12;
      sec_binary = 6'd60;
      check_digit(2, 0, 7'h3F, 1'b1);
      check_digit(2, 1, 7'h3F, 1'b1);
      check_digit(2, 2, 7'h24, 1'b0);
      check_digit(2, 3, 7'h79, 1'b1);

      // Frame 3: snapshot 00.07, input moves to 08 mid-conversion.
      min_binary = 6'd0;
      sec_binary = 6'd7;
      goto_edge(196);
      check("conv_during_change", {7'h0, conv_busy}, 8'h01);
      sec_binary = 6'd8;
      check_digit(3, 0, 7'h78, 1'b1);
      check_digit(3, 1, 7'h40, 1'b1);
      check_digit(3, 2, 7'h40, 1'b1);
      check_digit(3, 3, 7'h40, 1'b1);

      // Frame 4: full anode sweep; 07 held until the commit, then 08.
      for (int n = 257; n <= 320; n++) begin
         goto_edge(n);
         p = (n - 1) % 16;
         d = ((n - 1) / 16) % 4;
         a_exp = (p < 2) ? 4'b1111 : ~(4'b0001 << d);
         check($sformatf("sweep_an_e%0d", n), {4'h0, an}, {4'h0, a_exp});
         if (n == 265) check("old_snap_seg", {1'b0, seg}, 8'h78);
         if (n == 269) check("new_snap_seg", {1'b0, seg}, 8'h00);
         if (n == 301) check("new_snap_dp", {7'h0, dp}, 8'h00);
      end

      // Frame 5: reset in the middle of converting 33.00.
      min_binary = 6'd33;
      sec_binary = 6'd0;
      goto_edge(324);
      check("conv_before_abort", {7'h0, conv_busy}, 8'h01);
      reset = 1'b1;
      #1;
      check_reset_outputs("abort");
      repeat (2) @(negedge clk_100M);
      reset = 1'b0;
      goto_edge(2);
      check("busy_after_abort", {7'h0, conv_busy}, 8'h01);
      check_digit(0, 0, 7'h40, 1'b1);
      check_digit(0, 1, 7'h40, 1'b1);
      check_digit(0, 2, 7'h30, 1'b0);
      check_digit(0, 3, 7'h30, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
